// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side bundle for the multiply/divide sequencer: request, operands,
// HI/LO read port and status.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             rd_req;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] outHI;
    logic [WIDTH-1:0] outLO;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, sign, A, B, rd_req, rd_sel,
        input  rd_data, outHI, outLO, busy, stall, done, div_zero
    );

    modport slave (
        input  start, op, sign, A, B, rd_req, rd_sel,
        output rd_data, outHI, outLO, busy, stall, done, div_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Bit-serial MULT/DIV unit owning HI/LO, with MTHI/MTLO writes and MFHI/MFLO reads.
// Defining MULDIV_ABORT_EN adds an abort input that cancels an in-flight operation.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
`ifdef MULDIV_ABORT_EN
    input  logic abort,
`endif
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;

    logic               busy;
    logic               abort_hit;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign busy = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);

`ifdef MULDIV_ABORT_EN
    assign abort_hit = abort & busy;
`else
    assign abort_hit = 1'b0;
`endif

    // {acc, mq} is the shared shift register: product in MULT, remainder:quotient in DIV.
    always_comb begin
        a_neg   = sign_q & a_q[WIDTH-1];
        b_neg   = sign_q & b_q[WIDTH-1];
        sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mb_q} : '0);
        shifted = {acc_q, mq_q[WIDTH-1]};
        diff    = shifted - {1'b0, mb_q};
        prod    = neg_q ? -{acc_q, mq_q} : {acc_q, mq_q};
        quo     = neg_q ? -mq_q : mq_q;
        rem     = rneg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        a_d      = a_q;
        b_d      = b_q;
        mq_d     = mq_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    if (!bus.op[1]) begin
                        state_d  = S_PREP;
                        is_div_d = bus.op[0];
                        sign_d   = bus.sign;
                        a_d      = bus.A;
                        b_d      = bus.B;
                    end else if (bus.op[0]) begin
                        lo_d = bus.A;
                    end else begin
                        hi_d = bus.A;
                    end
                end
            end
            S_PREP: begin
                mq_d    = a_neg ? -a_q : a_q;
                mb_d    = b_neg ? -b_q : b_q;
                acc_d   = '0;
                cnt_d   = '0;
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
                dz_d    = is_div_q && (b_q == '0);
                state_d = S_RUN;
            end
            S_RUN: begin
                if (is_div_q) begin
                    // diff[WIDTH] is the borrow: the trial subtract failed, keep the shifted value.
                    if (!diff[WIDTH]) begin
                        acc_d = diff[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shifted[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = sum[WIDTH:1];
                    mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (dz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort also cancels the HI/LO write scheduled at the end of FIX.
        if (abort_hit) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mq_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mq_q     <= mq_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.rd_data  = bus.rd_sel ? hi_q : lo_q;
    assign bus.outHI    = hi_q;
    assign bus.outLO    = lo_q;
    assign bus.busy     = busy;
    assign bus.stall    = (bus.start | bus.rd_req) & busy;
    assign bus.done     = (state_q == S_DONE);
    assign bus.div_zero = (state_q == S_DONE) & dz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: reset, MULT/DIV results and latency,
// HI/LO moves and reads, stall behaviour, mid-run reset and optional abort.
module tb_muldiv_sequencer;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;
`ifdef MULDIV_ABORT_EN
    logic abort;
`endif
    int unsigned checks = 0;
    int unsigned errors = 0;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef MULDIV_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle after the accepting edge; returns at the done cycle (or after a bound).
    task automatic wait_done(input logic [W-1:0] rd_exp, output int unsigned n,
                             output int unsigned busy_n, output int unsigned stall_n,
                             output int unsigned rd_n, output int unsigned dz_n);
        n = 1; busy_n = 0; stall_n = 0; rd_n = 0; dz_n = 0;
        while (n < 100) begin
            #1;
            if (bus.done) break;
            if (bus.busy) busy_n++;
            if (bus.stall) stall_n++;
            if (bus.rd_data == rd_exp) rd_n++;
            if (bus.div_zero) dz_n++;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic s,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic exp_dz);
        int unsigned n, busy_n, stall_n, rd_n, dz_n;
        bus.start = 1'b1; bus.op = o; bus.sign = s; bus.A = a; bus.B = b;
        tick();
        bus.start = 1'b0; bus.A = ~a; bus.B = b ^ 32'h5A5A_0001;
        wait_done('0, n, busy_n, stall_n, rd_n, dz_n);
        check({tag, " latency"}, 64'(n), 64'd35);
        check({tag, " busy cycles"}, 64'(busy_n), 64'd34);
        check({tag, " early div_zero"}, 64'(dz_n), 64'd0);
        check({tag, " HI"}, 64'(bus.outHI), 64'(exp_hi));
        check({tag, " LO"}, 64'(bus.outLO), 64'(exp_lo));
        check({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
        tick();
        check({tag, " done after"}, 64'(bus.done), 64'd0);
        check({tag, " div_zero after"}, 64'(bus.div_zero), 64'd0);
        check({tag, " busy after"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic move(input logic hi, input logic [W-1:0] val);
        bus.start = 1'b1; bus.op = hi ? 2'b10 : 2'b11; bus.A = val;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        int unsigned n, busy_n, stall_n, rd_n, dz_n, done_n;

        // Reset with a request pending: reset must win.
        rst_n = 1'b0;
        bus.start = 1'b1; bus.op = 2'b00; bus.sign = 1'b0;
        bus.A = 32'd5; bus.B = 32'd5; bus.rd_req = 1'b1; bus.rd_sel = 1'b0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst div_zero", 64'(bus.div_zero), 64'd0);
        check("rst stall", 64'(bus.stall), 64'd0);
        check("rst HI", 64'(bus.outHI), 64'd0);
        check("rst LO", 64'(bus.outLO), 64'd0);
        bus.start = 1'b0; bus.rd_req = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post rst busy", 64'(bus.busy), 64'd0);

        // MTLO then read next cycle.
        move(1'b0, 32'h1234_5678);
        bus.rd_req = 1'b1; bus.rd_sel = 1'b0;
        #1;
        check("mtlo rd_data", 64'(bus.rd_data), 64'h1234_5678);
        check("mtlo stall", 64'(bus.stall), 64'd0);
        check("mtlo busy", 64'(bus.busy), 64'd0);
        check("mtlo done", 64'(bus.done), 64'd0);

        // MTHI with a same-cycle HI read returns the pre-write value.
        bus.start = 1'b1; bus.op = 2'b10; bus.A = 32'hCAFE_BABE; bus.rd_sel = 1'b1;
        #1;
        check("mthi same-cycle rd", 64'(bus.rd_data), 64'd0);
        check("mthi stall", 64'(bus.stall), 64'd0);
        tick();
        bus.start = 1'b0; bus.rd_req = 1'b0;
        #1;
        check("mthi HI", 64'(bus.outHI), 64'hCAFE_BABE);
        check("mthi LO kept", 64'(bus.outLO), 64'h1234_5678);
        check("mthi done", 64'(bus.done), 64'd0);
        check("mthi busy", 64'(bus.busy), 64'd0);

        run_op("umul max",  2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("smul -3*7", 2'b00, 1'b1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("umul fd*7", 2'b00, 1'b0, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
        run_op("smul min",  2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("umul shl",  2'b00, 1'b0, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, 1'b0);
        run_op("sdiv -7/2", 2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("sdiv 7/-2", 2'b01, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("udiv 1000/7", 2'b01, 1'b0, 32'd1000,    32'd7,         32'h0000_0006, 32'h0000_008E, 1'b0);
        run_op("sdiv min/-1", 2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("udiv by 0", 2'b01, 1'b0, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        run_op("sdiv by 0", 2'b01, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

        // MULT in flight with a held second start and an HI read.
        move(1'b1, 32'hA5A5_A5A5);
        bus.start = 1'b1; bus.op = 2'b00; bus.sign = 1'b0;
        bus.A = 32'h0001_0000; bus.B = 32'h0003_0000;
        tick();
        bus.A = 32'd2; bus.B = 32'd5; bus.rd_req = 1'b1; bus.rd_sel = 1'b1;
        wait_done(32'hA5A5_A5A5, n, busy_n, stall_n, rd_n, dz_n);
        check("stall latency", 64'(n), 64'd35);
        check("stall busy cycles", 64'(busy_n), 64'd34);
        check("stall cycles", 64'(stall_n), 64'd34);
        check("stall old HI reads", 64'(rd_n), 64'd34);
        check("done-cycle stall", 64'(bus.stall), 64'd0);
        check("done-cycle rd HI", 64'(bus.rd_data), 64'd3);
        check("done-cycle LO", 64'(bus.outLO), 64'd0);
        tick();
        bus.start = 1'b0; bus.rd_req = 1'b0;
        wait_done('0, n, busy_n, stall_n, rd_n, dz_n);
        check("second op latency", 64'(n), 64'd35);
        check("second op HI", 64'(bus.outHI), 64'd0);
        check("second op LO", 64'(bus.outLO), 64'd10);
        tick();

        // Synchronous reset in the middle of RUN.
        move(1'b1, 32'h0000_1111);
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'd7; bus.B = 32'd9;
        tick();
        bus.start = 1'b0;
        repeat (11) tick();
        check("pre-rst busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid rst busy", 64'(bus.busy), 64'd0);
        check("mid rst done", 64'(bus.done), 64'd0);
        check("mid rst HI", 64'(bus.outHI), 64'd0);
        check("mid rst LO", 64'(bus.outLO), 64'd0);
        done_n = 0;
        repeat (40) begin
            if (bus.done) done_n++;
            tick();
        end
        check("mid rst no done", 64'(done_n), 64'd0);

`ifdef MULDIV_ABORT_EN
        // Abort in RUN: back to IDLE, HI/LO untouched, no done.
        move(1'b1, 32'h0BAD_0BAD);
        move(1'b0, 32'h600D_600D);
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort run busy", 64'(bus.busy), 64'd0);
        check("abort run HI", 64'(bus.outHI), 64'h0BAD_0BAD);
        check("abort run LO", 64'(bus.outLO), 64'h600D_600D);
        done_n = 0;
        repeat (40) begin
            if (bus.done) done_n++;
            tick();
        end
        check("abort run no done", 64'(done_n), 64'd0);

        // Abort in IDLE has no effect on an MTLO.
        abort = 1'b1;
        move(1'b0, 32'h0000_0077);
        abort = 1'b0;
        check("abort idle LO", 64'(bus.outLO), 64'h0000_0077);

        // Abort in FIX suppresses the HI/LO write.
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'd3; bus.B = 32'd4;
        tick();
        bus.start = 1'b0;
        repeat (33) tick();
        check("abort fix pre busy", 64'(bus.busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort fix busy", 64'(bus.busy), 64'd0);
        check("abort fix done", 64'(bus.done), 64'd0);
        check("abort fix HI", 64'(bus.outHI), 64'h0BAD_0BAD);
        check("abort fix LO", 64'(bus.outLO), 64'h0000_0077);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
